// File: rtl/g_ibuf_filt.sv
// rtl/g_ibuf_filt.sv - clocked input buffer: pin synchronizer, qualified-sample glitch filter, edge strobes
module g_ibuf_filt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic A,
  input  logic CE,
  output logic Y,
  output logic RISE,
  output logic FALL,
  output logic BUSY
);

  localparam int CW = $clog2(FILT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYC - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nxt;
  logic                   y_nxt;
  logic                   rise_nxt;
  logic                   fall_nxt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // The synchronizer runs every edge; CE only qualifies filter samples.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], A};
    end
  end

  // A sample equal to Y restarts the count, so only an unbroken run of
  // FILT_CYC qualified mismatching samples moves Y.
  always_comb begin
    cnt_nxt  = cnt;
    y_nxt    = Y;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    if (s == Y) begin
      cnt_nxt = '0;
    end else if (CE) begin
      if (cnt == CNT_LAST) begin
        y_nxt    = s;
        cnt_nxt  = '0;
        rise_nxt = s;
        fall_nxt = ~s;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt  <= '0;
      Y    <= RST_VAL;
      RISE <= 1'b0;
      FALL <= 1'b0;
      BUSY <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      Y    <= y_nxt;
      RISE <= rise_nxt;
      FALL <= fall_nxt;
      BUSY <= (cnt_nxt != '0);
    end
  end

endmodule
